// File: rtl/bday_pkg.sv
// Shared constants and types for the birthday-sequence link.
// Used by both the transmitter and the receiver.
`timescale 1ns/1ps
package bday_pkg;

    localparam int PAT_LEN = 14;

    localparam logic [7:0] CH_H = 8'h48;
    localparam logic [7:0] CH_A = 8'h41;

    // "HAPPY BIRTHDAY", index 0 is the leftmost character
    localparam logic [0:PAT_LEN-1][7:0] PAT = {
        8'h48, 8'h41, 8'h50, 8'h50, 8'h59, 8'h20, 8'h42,
        8'h49, 8'h52, 8'h54, 8'h48, 8'h44, 8'h41, 8'h59
    };

    typedef logic [3:0] idx_t;

    // "H" recurs at index 10, so a stray 'A' at 11 keeps "HA"
    localparam idx_t IDX_FB_A    = 4'd11;
    localparam idx_t IDX_RESTART = 4'd2;

    typedef enum logic {
        ST_DISABLED = 1'b0,
        ST_RUN      = 1'b1
    } ctl_state_e;

endpackage

// File: rtl/bday_rx_deser.sv
// MSB-first serial to parallel converter.
// Emits a one-cycle strobe with each completed character.
`timescale 1ns/1ps
module bday_rx_deser #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic [DATA_W-1:0] data,
    output logic              data_valid
);

    localparam int CW = $clog2(DATA_W);

    logic [CW-1:0]     cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] next_shift;

    assign next_shift = {shift_q[DATA_W-2:0], bit_in};

    // shift in qualified bits; publish on the last bit of a char
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            shift_q    <= '0;
            data       <= '0;
            data_valid <= 1'b0;
        end else if (clr) begin
            cnt_q      <= '0;
            shift_q    <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (bit_valid) begin
                shift_q <= next_shift;
                cnt_q   <= cnt_q + 1'b1;
                if (cnt_q == CW'(DATA_W - 1)) begin
                    data       <= next_shift;
                    data_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bday_rx_top.sv
// Receive side of the birthday link: deserialise, then
// match "HAPPY BIRTHDAY" with KMP fallback and count hits.
`timescale 1ns/1ps
module bday_rx_top
    import bday_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 8,
    parameter int PAT_LEN = bday_pkg::PAT_LEN
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx_en_n,
    input  logic              i_rx_bit,
    input  logic              i_rx_valid,
    output logic [DATA_W-1:0] o_byte,
    output logic              o_byte_valid,
    output logic              o_detect,
    output logic [3:0]        o_match_idx,
    output logic [CNT_W-1:0]  o_seq_count
);

    localparam idx_t IDX_LAST = idx_t'(PAT_LEN - 1);

    ctl_state_e state_q;
    ctl_state_e state_d;
    logic       run;

    idx_t       idx_q;
    logic       hit;
    logic       fb_a;
    logic       is_h;

    // control state tracks the enable on every edge
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_DISABLED;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and the run qualifier for datapath
    always_comb begin
        state_d = state_q;
        run     = 1'b0;
        unique case (state_q)
            ST_DISABLED: begin
                if (!i_rx_en_n) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (i_rx_en_n) state_d = ST_DISABLED;
            end
            default: state_d = ST_DISABLED;
        endcase
        run = !i_rx_en_n;
    end

    bday_rx_deser #(
        .DATA_W(DATA_W)
    ) u_deser (
        .clk       (i_clk),
        .rst       (i_rst),
        .clr       (!run),
        .bit_valid (i_rx_valid),
        .bit_in    (i_rx_bit),
        .data      (o_byte),
        .data_valid(o_byte_valid)
    );

    assign hit  = (o_byte == PAT[idx_q]);
    assign is_h = (o_byte == CH_H);
    assign fb_a = (idx_q == IDX_FB_A)
               && (o_byte == CH_A);

    // matcher, detect pulse and saturating detection count
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx_q       <= '0;
            o_detect    <= 1'b0;
            o_seq_count <= '0;
        end else if (!run) begin
            idx_q    <= '0;
            o_detect <= 1'b0;
        end else begin
            o_detect <= 1'b0;
            if (o_byte_valid) begin
                unique case (1'b1)
                    hit && (idx_q == IDX_LAST): begin
                        idx_q    <= '0;
                        o_detect <= 1'b1;
                        if (o_seq_count != '1)
                            o_seq_count <= o_seq_count + 1'b1;
                    end
                    hit && (idx_q != IDX_LAST):
                        idx_q <= idx_q + 4'd1;
                    !hit && fb_a:
                        idx_q <= IDX_RESTART;
                    !hit && !fb_a && is_h:
                        idx_q <= 4'd1;
                    default:
                        idx_q <= '0;
                endcase
            end
        end
    end

    assign o_match_idx = idx_q;

endmodule
